branch_offset_encoder: RTL

- Pipelined encoder that converts an absolute branch target into the 16-bit branch immediate the datapath's sign-extend/shift-left-2 path consumes.
- Computes `(target - (pc + 4)) >>> 2` and flags targets that are misaligned or out of range.
- Sits between the in-system instruction patcher/assembler front end and instruction-memory write logic.
- Uses a two-stage valid/ready pipeline with full throughput and backpressure.

---
 rtl/branch_offset_encoder.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/branch_offset_encoder.sv
// branch_offset_encoder
// Two-stage valid/ready pipeline that turns an absolute branch target into
// the 16-bit word-offset immediate, (target - (pc + PC_INC)) >>> 2, and flags
// misaligned or out-of-range offsets.
// Stage 1 holds the 32-bit byte offset. Stage 2 holds the registered result
// fields, which drive the out_* ports directly.
// Optional feature macro: BOE_ERR_COUNT_EN enables the saturating error
// counter on err_count. Without it, err_count is tied to zero.
module branch_offset_encoder #(
    parameter int unsigned PC_INC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_target,
    input  logic [4:0]  in_tag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_imm,
    output logic        out_misaligned,
    output logic        out_range_err,
    output logic [4:0]  out_tag,
    output logic [15:0] err_count
);

    localparam logic [31:0] LP_PC_INC = 32'(PC_INC);

    // The word offset is diff[31:2], read as a signed 30-bit value. It fits in
    // signed 16 bits only when bits [29:15] of that value are all copies of the
    // sign, i.e. diff[31:17] is all ones or all zeros.
    function automatic logic f_range_err(input logic [31:0] diff);
        logic [14:0] upper;
        upper = diff[31:17];
        return !((&upper) || (~|upper));
    endfunction

    // A branch offset must be a whole number of 32-bit instructions.
    function automatic logic f_misaligned(input logic [31:0] diff);
        return (diff[1:0] != 2'b00);
    endfunction

    // Stage 1 state
    logic        r_s1_valid;
    logic [31:0] r_s1_diff;
    logic [4:0]  r_s1_tag;

    // Stage 2 state (these are the output registers)
    logic        r_s2_valid;
    logic [15:0] r_s2_imm;
    logic        r_s2_misaligned;
    logic        r_s2_range_err;
    logic [4:0]  r_s2_tag;

    // Combinational control and datapath
    logic        w_s2_load;
    logic        w_s1_load;
    logic        w_in_fire;
    logic [31:0] w_diff;
    logic [15:0] w_imm;
    logic        w_misaligned;
    logic        w_range_err;

    // Handshake control. Stage 2 can take new data when it is empty or its
    // result is being consumed. Stage 1 can take new data when it is empty or
    // its contents are moving into stage 2. in_ready does not look at in_valid.
    always_comb begin
        w_s2_load = 1'b0;
        w_s1_load = 1'b0;
        w_in_fire = 1'b0;
        if (!r_s2_valid || out_ready) begin
            w_s2_load = 1'b1;
        end else begin
            w_s2_load = 1'b0;
        end
        if (!r_s1_valid || w_s2_load) begin
            w_s1_load = 1'b1;
        end else begin
            w_s1_load = 1'b0;
        end
        if (in_valid && w_s1_load) begin
            w_in_fire = 1'b1;
        end else begin
            w_in_fire = 1'b0;
        end
    end

    assign in_ready = w_s1_load;

    // Byte offset from the branch base, modulo 2^32. This makes address wrap
    // around the top of memory behave like any other offset.
    always_comb begin
        w_diff = 32'h0000_0000;
        w_diff = in_target - in_pc - LP_PC_INC;
    end

    // Result fields, computed from the stage 1 offset. The immediate is always
    // the truncated word offset, even when an error flag is raised.
    always_comb begin
        w_imm        = 16'h0000;
        w_misaligned = 1'b0;
        w_range_err  = 1'b0;
        w_imm        = r_s1_diff[17:2];
        w_misaligned = f_misaligned(r_s1_diff);
        w_range_err  = f_range_err(r_s1_diff);
    end

    // Stage 1 register: capture the byte offset and tag of each accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_diff  <= 32'h0000_0000;
            r_s1_tag   <= 5'd0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (w_in_fire) begin
                r_s1_diff <= w_diff;
                r_s1_tag  <= in_tag;
            end else begin
                r_s1_diff <= r_s1_diff;
                r_s1_tag  <= r_s1_tag;
            end
        end else begin
            r_s1_valid <= r_s1_valid;
            r_s1_diff  <= r_s1_diff;
            r_s1_tag   <= r_s1_tag;
        end
    end

    // Stage 2 register: load the result fields when stage 2 frees up. While
    // the consumer stalls, the fields hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid      <= 1'b0;
            r_s2_imm        <= 16'h0000;
            r_s2_misaligned <= 1'b0;
            r_s2_range_err  <= 1'b0;
            r_s2_tag        <= 5'd0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_imm        <= w_imm;
                r_s2_misaligned <= w_misaligned;
                r_s2_range_err  <= w_range_err;
                r_s2_tag        <= r_s1_tag;
            end else begin
                r_s2_imm        <= r_s2_imm;
                r_s2_misaligned <= r_s2_misaligned;
                r_s2_range_err  <= r_s2_range_err;
                r_s2_tag        <= r_s2_tag;
            end
        end else begin
            r_s2_valid      <= r_s2_valid;
            r_s2_imm        <= r_s2_imm;
            r_s2_misaligned <= r_s2_misaligned;
            r_s2_range_err  <= r_s2_range_err;
            r_s2_tag        <= r_s2_tag;
        end
    end

    assign out_valid      = r_s2_valid;
    assign out_imm        = r_s2_imm;
    assign out_misaligned = r_s2_misaligned;
    assign out_range_err  = r_s2_range_err;
    assign out_tag        = r_s2_tag;

`ifdef BOE_ERR_COUNT_EN
    logic        w_out_fire;
    logic [15:0] r_err_count;

    assign w_out_fire = r_s2_valid && out_ready;

    // Error counter: count each consumed result that carries an error flag.
    // The counter stops at 0xFFFF instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= 16'h0000;
        end else if (w_out_fire && (r_s2_misaligned || r_s2_range_err) &&
                     (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'h0001;
        end else begin
            r_err_count <= r_err_count;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = 16'h0000;
`endif

endmodule
